// File: rtl/hack_pc_pkg.sv
// Shared types for the Hack PC / return-stack slice: op encoding, priority decode, reset vector.
package hack_pc_pkg;

  localparam int unsigned RESET_VEC_DEF = 0;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_INC  = 3'd4
  } op_e;

  // Fixed priority: load > call > ret > inc > hold.
  function automatic op_e decode_op(input logic load, input logic call,
                                    input logic ret, input logic inc);
    if (load)      return OP_LOAD;
    else if (call) return OP_CALL;
    else if (ret)  return OP_RET;
    else if (inc)  return OP_INC;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/hack_pc_stack_if.sv
// Control/status bundle between the fetch stage and hack_pc_stack.
interface hack_pc_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic             en;
  logic             load;
  logic             call;
  logic             ret;
  logic             inc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [LW-1:0]    depth_lvl;
  logic             stack_full;
  logic             stack_empty;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output en, load, call, ret, inc, target,
    input  pc, depth_lvl, stack_full, stack_empty, err_ovf, err_unf
  );

  modport slave (
    input  en, load, call, ret, inc, target,
    output pc, depth_lvl, stack_full, stack_empty, err_ovf, err_unf
  );
endinterface

// File: rtl/hack_ret_stack.sv
// Return-address LIFO. Define HACK_PC_STACK_CIRC_EN to make a full push overwrite
// the oldest entry instead of being dropped.
module hack_ret_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic             do_push;
  logic             do_pop;

  // sp wraps modulo DEPTH, so a circular push lands on the oldest slot.
`ifdef HACK_PC_STACK_CIRC_EN
  assign do_push = push;
`else
  assign do_push = push && !full;
`endif
  assign do_pop = pop && !empty && !push;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      level <= '0;
    end else if (do_push) begin
      sp <= sp + AW'(1);
      if (!full) level <= level + LW'(1);
    end else if (do_pop) begin
      sp    <= sp - AW'(1);
      level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[sp] <= din;
  end

  assign dout  = mem[sp - AW'(1)];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/hack_pc_stack.sv
// Hack program counter with return-address stack for call/ret.
// Build option HACK_PC_STACK_CIRC_EN: circular stack (full call overwrites oldest, still flags err_ovf).
module hack_pc_stack
  import hack_pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned RESET_VEC = RESET_VEC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hack_pc_stack_if.slave   bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  op_e              op;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stk_top;
  logic [LW-1:0]    stk_level;
  logic             stk_full;
  logic             stk_empty;
  logic             call_ok;
  logic             push;
  logic             pop;
  logic             err_ovf;
  logic             err_unf;

  assign op     = decode_op(bus.load, bus.call, bus.ret, bus.inc);
  assign pc_inc = pc + WIDTH'(1);

`ifdef HACK_PC_STACK_CIRC_EN
  assign call_ok = 1'b1;
`else
  assign call_ok = !stk_full;
`endif

  // Reset discards any op in the same cycle.
  assign push = !reset && bus.en && (op == OP_CALL) && call_ok;
  assign pop  = !reset && bus.en && (op == OP_RET) && !stk_empty;

  always_comb begin
    pc_next = pc;
    unique case (op)
      OP_LOAD: pc_next = bus.target;
      OP_CALL: if (call_ok) pc_next = bus.target;
      OP_RET:  if (!stk_empty) pc_next = stk_top;
      OP_INC:  pc_next = pc_inc;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= WIDTH'(RESET_VEC);
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (bus.en) begin
      pc <= pc_next;
      if (op == OP_CALL && stk_full)  err_ovf <= 1'b1;
      if (op == OP_RET  && stk_empty) err_unf <= 1'b1;
    end
  end

  hack_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .level (stk_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.pc          = pc;
  assign bus.depth_lvl   = stk_level;
  assign bus.stack_full  = stk_full;
  assign bus.stack_empty = stk_empty;
  assign bus.err_ovf     = err_ovf;
  assign bus.err_unf     = err_unf;

endmodule

// File: tb/tb_hack_pc_stack.sv
// Bench for hack_pc_stack: queue-based reference model checked every cycle plus literal pins.
module tb_hack_pc_stack;

  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  hack_pc_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  hack_pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pc as plain value, stack as a queue (back = top).
  logic [W-1:0] m_pc;
  logic [W-1:0] m_q [$];
  bit           m_ovf;
  bit           m_unf;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = '0;
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (bus.en) begin
      if (bus.load) begin
        m_pc = bus.target;
      end else if (bus.call) begin
        if (m_q.size() < D) begin
          m_q.push_back(m_pc + 16'd1);
          m_pc = bus.target;
        end else begin
          m_ovf = 1'b1;
`ifdef HACK_PC_STACK_CIRC_EN
          void'(m_q.pop_front());
          m_q.push_back(m_pc + 16'd1);
          m_pc = bus.target;
`endif
        end
      end else if (bus.ret) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else m_unf = 1'b1;
      end else if (bus.inc) begin
        m_pc = m_pc + 16'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("depth_lvl", 32'(bus.depth_lvl), 32'(m_q.size()));
    chk("stack_full", 32'(bus.stack_full), 32'(m_q.size() == D));
    chk("stack_empty", 32'(bus.stack_empty), 32'(m_q.size() == 0));
    chk("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
    chk("err_unf", 32'(bus.err_unf), 32'(m_unf));
  end

  task automatic drive(input logic en, input logic ld, input logic cl, input logic rt,
                       input logic in, input logic [W-1:0] tgt);
    bus.en = en; bus.load = ld; bus.call = cl; bus.ret = rt; bus.inc = in; bus.target = tgt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.inc = 1'b0;
    bus.target = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_empty", 32'(bus.stack_empty), 32'h1);
    reset = 1'b0;

    // inc x3
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 1, '0);
      chk("inc_pc", 32'(bus.pc), 32'(i));
    end

    // call / inc / ret
    drive(1, 1, 0, 0, 0, 16'h0010);
    drive(1, 0, 1, 0, 0, 16'h0100);
    chk("call_pc", 32'(bus.pc), 32'h0100);
    chk("call_lvl", 32'(bus.depth_lvl), 32'h1);
    drive(1, 0, 0, 0, 1, '0);
    chk("call_inc", 32'(bus.pc), 32'h0101);
    drive(1, 0, 0, 1, 0, '0);
    chk("ret_pc", 32'(bus.pc), 32'h0011);
    chk("ret_lvl", 32'(bus.depth_lvl), 32'h0);

    // nine calls against an eight-deep stack
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1, 0, 0, 16'h0200 + 16'(i));
      if (i == 7) chk("full_after8", 32'(bus.stack_full), 32'h1);
    end
`ifdef HACK_PC_STACK_CIRC_EN
    chk("ovf_pc", 32'(bus.pc), 32'h0208);
`else
    chk("ovf_pc", 32'(bus.pc), 32'h0207);
`endif
    chk("ovf_flag", 32'(bus.err_ovf), 32'h1);
    chk("ovf_lvl", 32'(bus.depth_lvl), 32'h8);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 1, 0, '0);
`ifdef HACK_PC_STACK_CIRC_EN
      chk("ret_seq", 32'(bus.pc), 32'h0208 - 32'(i));
`else
      if (i < 7) chk("ret_seq", 32'(bus.pc), 32'h0207 - 32'(i));
      else       chk("ret_seq", 32'(bus.pc), 32'h0012);
`endif
    end

    // underflow stays sticky
    drive(1, 1, 0, 0, 0, 16'h0042);
    drive(1, 0, 0, 1, 0, '0);
    chk("unf_pc", 32'(bus.pc), 32'h0042);
    chk("unf_flag", 32'(bus.err_unf), 32'h1);
    repeat (5) drive(1, 0, 0, 0, 1, '0);
    chk("unf_sticky", 32'(bus.err_unf), 32'h1);
    chk("unf_pc5", 32'(bus.pc), 32'h0047);

    // priority, stall, wrap
    drive(1, 1, 1, 0, 1, 16'h1234);
    chk("prio_pc", 32'(bus.pc), 32'h1234);
    chk("prio_lvl", 32'(bus.depth_lvl), 32'h0);
    repeat (4) drive(0, 0, 0, 0, 1, '0);
    chk("stall_pc", 32'(bus.pc), 32'h1234);
    drive(0, 0, 1, 0, 0, 16'h5555);
    chk("stall_call_lvl", 32'(bus.depth_lvl), 32'h0);
    drive(1, 1, 0, 0, 0, 16'hFFFF);
    drive(1, 0, 0, 0, 1, '0);
    chk("wrap_pc", 32'(bus.pc), 32'h0000);

    // reset during a call at depth 3
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, 16'h0300 + 16'(i));
    chk("pre_rst_lvl", 32'(bus.depth_lvl), 32'h3);
    reset = 1'b1;
    drive(1, 0, 1, 0, 0, 16'h0400);
    chk("midrst_pc", 32'(bus.pc), 32'h0);
    chk("midrst_lvl", 32'(bus.depth_lvl), 32'h0);
    chk("midrst_ovf", 32'(bus.err_ovf), 32'h0);
    chk("midrst_unf", 32'(bus.err_unf), 32'h0);
    reset = 1'b0;
    drive(1, 0, 0, 0, 1, '0);
    chk("post_rst_pc", 32'(bus.pc), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_pc_stack.md
Name: hack_pc_stack

Overview:
- Parametrised Hack program counter with an integrated return-address stack (LIFO) for call/return.
- Sits in the CPU fetch stage; drives the instruction-ROM address.
- Adds width/depth parameters, reset vector, stall enable, call/ret ops and stack status/error flags.

Parameters:
WIDTH, 16, PC and target address width in bits
DEPTH, 8, return-stack entries (power of two, >=2)
RESET_VEC, 0, PC value after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
en  input  1  advance enable; 0 = stall, all state holds
load  input  1  jump: pc <= target
call  input  1  push pc+1, then pc <= target
ret  input  1  pc <= top of stack, pop
inc  input  1  pc <= pc+1
target  input  WIDTH  jump/call destination
pc  output  WIDTH  current program counter (registered)
depth_lvl  output  $clog2(DEPTH)+1  number of valid stack entries
stack_full  output  1  depth_lvl == DEPTH
stack_empty  output  1  depth_lvl == 0
err_ovf  output  1  sticky: call attempted while full
err_unf  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (sampled at posedge): pc=RESET_VEC, depth_lvl=0, stack_empty=1, stack_full=0, err_ovf=0, err_unf=0. Reset overrides en and all ops. Stack contents need not be cleared.
- en=0: pc, stack, depth_lvl and error flags all hold. Op inputs are ignored.
- en=1, fixed priority: load > call > ret > inc > hold. Only the highest asserted op acts; lower ops in the same cycle are ignored, including for error flags.
- load: pc <= target next cycle. Stack unchanged.
- call, not full: stack[depth_lvl] <= pc+1 (mod 2^WIDTH); depth_lvl+1; pc <= target.
- call, full: pc holds, stack unchanged, err_ovf <= 1.
- ret, not empty: pc <= stack[depth_lvl-1]; depth_lvl-1.
- ret, empty: pc holds, err_unf <= 1.
- inc: pc <= pc+1, wraps (2^WIDTH-1 -> 0) silently.
- Latency: every op is visible on pc one cycle after the enabling edge. Status outputs are combinational from depth_lvl, so they reflect the post-update level in the same cycle.
- Error flags clear only on reset.
- Reset asserted mid-sequence (e.g. with call) discards the op. The stack restarts empty.

Optional Feature:
HACK_PC_STACK_CIRC_EN
- Defined: stack is circular. call when full still pushes, overwriting the oldest entry. pc <= target; depth_lvl stays DEPTH; err_ovf is set anyway as a warning.
- Undefined: full-stack call behaves as specified above (ignored, err_ovf set).
- ret behaviour is identical in both builds.

Decomposition:
- Package hack_pc_pkg:
  - op encoding enum (OP_HOLD, OP_LOAD, OP_CALL, OP_RET, OP_INC)
  - priority-decode function mapping {load,call,ret,inc} to op
  - RESET_VEC default constant
- Sub-module hack_ret_stack:
  - parametrised LIFO (WIDTH, DEPTH)
  - push/pop/data ports, level and full/empty outputs, circular-mode logic under the macro
- hack_pc_stack holds the pc register, op decode and error flags.

Test Plan:
- Reset then inc x3 with en=1 (WIDTH=16, RESET_VEC=0) -> pc 0,1,2,3; stack_empty=1; both errors 0.
- pc=0x0010, call target=0x0100; then inc; then ret -> pc 0x0100, 0x0101, then 0x0011; depth_lvl 1 then 0.
- DEPTH=8, 9 consecutive calls -> after the 8th, stack_full=1. The 9th leaves pc at the 8th target and sets err_ovf=1. With HACK_PC_STACK_CIRC_EN instead: pc=9th target, depth_lvl=8, and 8 rets return addresses of calls 9..2.
- ret with stack empty, pc=0x0042 -> pc stays 0x0042, err_unf=1 and remains set after 5 further inc cycles.
- load=1, call=1, inc=1 together, target=0x1234 -> pc=0x1234, depth_lvl unchanged. en=0 with inc for 4 cycles -> pc unchanged. pc=0xFFFF plus inc -> 0x0000.
- Reset asserted during call with depth_lvl=3 -> next cycle pc=RESET_VEC, depth_lvl=0, err flags 0.
